rx_copy_sequencer: RTL and testbench
====================================

// Module: rx_copy_sequencer
// PURPOSE
//  Receive-side controller for the five-way redundant link. Watches raw rx_en_w/rxdata_w, extracts the copy id
//  of each frame, and groups copies 1..NCOPIES of one transmission. Tells the five2one merger which copy to forward
//  (first good copy) and when a group is closed, reporting a lost/arrival mask per group.
// PARAMETERS
//  WHEREISID  0     byte offset of copy id within frame (id = low 4 bits of that byte)
//  NCOPIES    5     copies per group, legal ids 1..NCOPIES (max 7)
//  MINLEN     8     min frame length in bytes; shorter frames are runts, ignored
//  TIMEOUT    1024  idle cycles after last frame end that close an open group (>=2)
// PORTS
//  clk        in   1        single clock
//  rst        in   1        synchronous, active-high reset
//  rx_en_w    in   1        frame valid, high for every byte of a frame
//  rxdata_w   in   8        frame byte
//  fwd_sel    out  1        high for all bytes of the frame five2one forwards (first accepted copy of group)
//  pkt_done   out  1        1-cycle pulse, cycle after rx_en_w falls on an accepted frame
//  pkt_id     out  4        id of last accepted frame, valid with pkt_done, held until next
//  grp_open   out  1        a group is in progress
//  grp_done   out  1        1-cycle pulse when a group closes
//  grp_mask   out  NCOPIES  bit i-1 set = copy i arrived; valid with grp_done, held until next
//  grp_count  out  3        popcount of grp_mask, same timing
//  lost       out  1        1-cycle pulse with grp_done when grp_mask != all-ones
// BEHAVIOUR
//  Reset: all outputs 0; FSM -> SKIP (rx_en_w high at reset release -> rest of that frame is discarded).
//  FSM: SKIP (wait rx_en_w=0) -> IDLE; IDLE --rx_en_w--> RECV; RECV --!rx_en_w--> EVAL (1 cycle) -> IDLE.
//  Byte counter: 0 on first byte, saturates at 255; id latched when counter==WHEREISID.
//  Accept in EVAL: length>=MINLEN and 1<=id<=NCOPIES and mask bit for id clear; else frame ignored (no pulses,
//   timeout counter not reset). Duplicate id in open group = ignored.
//  Group rules, evaluated in EVAL for an accepted frame:
//   - grp_open and id <= last accepted id: close current group (grp_done, mask of old group), then open new
//     group with this frame in the same cycle; new mask = only this bit.
//   - !grp_open: open group, mask = this bit.
//   - otherwise set mask bit.
//   - if id==NCOPIES after update: close group this cycle (grp_done same cycle as pkt_done).
//  fwd_sel: decided at first byte from grp_open: asserted combinationally on rx_en_w bytes of a frame when no
//   copy of the current group has been forwarded yet; if that frame is later rejected, next frame is eligible.
//   Frames starting after a wrap (id<=last) are not known to start a new group at byte 0 -> fwd_sel decision
//   uses "forward pending" flag, set when a group closes or opens, cleared on accept of a forwarded frame.
//  Timeout: counter runs in IDLE while grp_open, reset at each accept; at count==TIMEOUT-1 group closes
//   (grp_done). Timeout and a new frame's first byte on same cycle: timeout closes first; the frame opens a
//   new group.
//  grp_mask/grp_count latched at close; lost = (count != NCOPIES).
//  Reset mid-frame or mid-group: group discarded silently, no grp_done.
//  Latency: pkt_done 1 cycle after rx_en_w falls; grp_done same cycle as closing event.
// STRUCTURE
//  Shared pkg (redundancy_pkg): NCOPIES, ID_W=4, FSM state encoding (SKIP/IDLE/RECV/EVAL).
//  One sub-module natural: frame_hdr_capture (byte counter, id latch, length check, runt flag) -> used by
//   five2one as well. Group mask/timeout logic stays in this module.
// TESTING
//  1 Ids 1..5, 35-byte frames, gap 20 cycles -> 5 pkt_done, grp_done with id 5, mask 11111, count 5, lost=0;
//    fwd_sel high only on frame id1.
//  2 Ids 1,2,4,5 (3 dropped) -> grp_done on id 5, mask 11011, count 4, lost=1.
//  3 Ids 1,3 then idle TIMEOUT cycles -> grp_done exactly TIMEOUT cycles after id3 pkt_done, mask 00101, lost=1.
//  4 Ids 2,3 then 1,2,... (wrap, no id5) -> grp_done at EVAL of second id1, mask 00110; new group mask 00001.
//  5 Runt (4 bytes, id1), id 0 frame, id 9 frame, duplicate id2 -> no pkt_done for any; fwd_sel moves to next
//    good frame; mask unaffected.
//  6 rst pulsed mid-frame of id3 with group open -> no grp_done, outputs 0, tail of frame ignored (SKIP),
//    following id1 frame opens fresh group.

Source files
------------

// File: rtl/rx_copy_sequencer_pkg.sv
// Shared definitions for the redundant-link receive path: copy id type, header summary
// and the sequencer FSM encoding.
package rx_copy_sequencer_pkg;

    localparam int unsigned NCopiesDef = 5;
    localparam int unsigned IdW        = 4;

    localparam logic [1:0] StSkip = 2'd0;
    localparam logic [1:0] StIdle = 2'd1;
    localparam logic [1:0] StRecv = 2'd2;
    localparam logic [1:0] StEval = 2'd3;

    typedef logic [IdW-1:0] copy_id_t;

    typedef struct packed {
        copy_id_t id;
        logic     runt;
    } hdr_info_t;

endpackage

// File: rtl/rx_copy_sequencer_if.sv
// Raw receive stream in, merger steering and per-group status out.
interface rx_copy_sequencer_if #(
    parameter int unsigned NCOPIES = 5
) ();

    logic               rx_en_w;
    logic [7:0]         rxdata_w;
    logic               fwd_sel;
    logic               pkt_done;
    logic [3:0]         pkt_id;
    logic               grp_open;
    logic               grp_done;
    logic [NCOPIES-1:0] grp_mask;
    logic [2:0]         grp_count;
    logic               lost;

    modport master (
        output rx_en_w, rxdata_w,
        input  fwd_sel, pkt_done, pkt_id, grp_open, grp_done, grp_mask, grp_count, lost
    );

    modport slave (
        input  rx_en_w, rxdata_w,
        output fwd_sel, pkt_done, pkt_id, grp_open, grp_done, grp_mask, grp_count, lost
    );

endinterface

// File: rtl/rx_copy_sequencer_frame_hdr_capture.sv
// Per-frame byte counter and copy-id latch; summary is stable in the cycle after rx_en_i falls.
module rx_copy_sequencer_frame_hdr_capture
    import rx_copy_sequencer_pkg::*;
#(
    parameter int unsigned WHEREISID = 0,
    parameter int unsigned MINLEN    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_en_i,
    input  logic [7:0] rxdata_i,
    output hdr_info_t  hdr_o
);

    localparam logic [7:0] IdIdx  = 8'(WHEREISID);
    localparam logic [7:0] MinLen = 8'(MINLEN);

    logic       active_q, active_d;
    logic [7:0] idx_q, idx_d;
    copy_id_t   id_q, id_d;
    logic [7:0] cur_idx;
    logic       unused_hi;

    assign unused_hi = ^rxdata_i[7:IdW];
    // idx_q holds the number of bytes seen so far, i.e. the index of the next byte
    assign cur_idx = active_q ? idx_q : 8'd0;

    always_comb begin
        active_d = rx_en_i;
        idx_d    = idx_q;
        id_d     = id_q;
        if (rx_en_i) begin
            idx_d = (cur_idx == 8'hFF) ? 8'hFF : cur_idx + 8'd1;
            if (cur_idx == IdIdx) begin
                id_d = rxdata_i[IdW-1:0];
            end else if (cur_idx == 8'd0) begin
                id_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            idx_q    <= '0;
            id_q     <= '0;
        end else begin
            active_q <= active_d;
            idx_q    <= idx_d;
            id_q     <= id_d;
        end
    end

    assign hdr_o.id   = id_q;
    assign hdr_o.runt = (idx_q < MinLen);

endmodule

// File: rtl/rx_copy_sequencer.sv
// Groups redundant copies of a transmission, steers the merger to the first good copy and
// reports which copies of each group arrived.
module rx_copy_sequencer
    import rx_copy_sequencer_pkg::*;
#(
    parameter int unsigned WHEREISID = 0,
    parameter int unsigned NCOPIES   = NCopiesDef,
    parameter int unsigned MINLEN    = 8,
    parameter int unsigned TIMEOUT   = 1024
) (
    input logic               clk,
    input logic               rst,
    rx_copy_sequencer_if.slave bus_io
);

    localparam int unsigned        TmoW    = $clog2(TIMEOUT);
    localparam logic [TmoW-1:0]    TmoLast = TmoW'(TIMEOUT - 1);
    localparam copy_id_t           IdMax   = copy_id_t'(NCOPIES);
    localparam logic [NCOPIES-1:0] Bit0    = {{(NCOPIES-1){1'b0}}, 1'b1};

    function automatic logic [2:0] popcnt(input logic [NCOPIES-1:0] m);
        logic [2:0] c;
        c = '0;
        for (int unsigned i = 0; i < NCOPIES; i++) c = c + {2'b00, m[i]};
        return c;
    endfunction

    logic [1:0]         state_q, state_d;
    logic               grp_open_q, grp_open_d;
    logic [NCOPIES-1:0] mask_q, mask_d;
    copy_id_t           last_id_q, last_id_d;
    logic               fwd_pend_q, fwd_pend_d;
    logic               fwd_frame_q, fwd_frame_d;
    logic [TmoW-1:0]    tmo_q, tmo_d;
    copy_id_t           pkt_id_q, pkt_id_d;
    logic [NCOPIES-1:0] grp_mask_q, grp_mask_d;
    logic [2:0]         grp_count_q, grp_count_d;

    hdr_info_t          hdr;
    logic               rx_en, in_idle, first_byte, tmo_fire, fwd_eligible;
    logic               id_ok, accept, wrap, full, grp_done;
    logic [NCOPIES-1:0] id_bit, new_mask, close_mask;

    rx_copy_sequencer_frame_hdr_capture #(
        .WHEREISID(WHEREISID),
        .MINLEN   (MINLEN)
    ) u_hdr (
        .clk     (clk),
        .rst     (rst),
        .rx_en_i (bus_io.rx_en_w),
        .rxdata_i(bus_io.rxdata_w),
        .hdr_o   (hdr)
    );

    assign rx_en        = bus_io.rx_en_w;
    assign in_idle      = (state_q == StIdle);
    assign first_byte   = in_idle && rx_en;
    assign tmo_fire     = !rst && in_idle && grp_open_q && (tmo_q == TmoLast);
    // A timeout on the first byte closes the group first, so that frame may be forwarded
    assign fwd_eligible = fwd_pend_q || tmo_fire;

    assign id_ok    = (hdr.id != '0) && (hdr.id <= IdMax);
    assign id_bit   = Bit0 << (hdr.id - copy_id_t'(1));
    assign accept   = !rst && (state_q == StEval) && !hdr.runt && id_ok &&
                      ((mask_q & id_bit) == '0);
    assign wrap     = grp_open_q && (hdr.id <= last_id_q);
    assign full     = (hdr.id == IdMax);
    assign new_mask = ((grp_open_q && !wrap) ? mask_q : '0) | id_bit;
    assign grp_done = tmo_fire || (accept && (wrap || full));
    assign close_mask = (tmo_fire || wrap) ? mask_q : new_mask;

    always_comb begin
        state_d     = state_q;
        grp_open_d  = grp_open_q;
        mask_d      = mask_q;
        last_id_d   = last_id_q;
        fwd_pend_d  = fwd_pend_q;
        fwd_frame_d = fwd_frame_q;
        tmo_d       = tmo_q;
        pkt_id_d    = pkt_id_q;
        grp_mask_d  = grp_mask_q;
        grp_count_d = grp_count_q;

        case (state_q)
            StSkip:  if (!rx_en) state_d = StIdle;
            StIdle:  if (rx_en) state_d = StRecv;
            StRecv:  if (!rx_en) state_d = StEval;
            default: state_d = StIdle;
        endcase

        if (first_byte) fwd_frame_d = fwd_eligible;
        if (in_idle && grp_open_q) tmo_d = tmo_q + TmoW'(1);

        if (tmo_fire) begin
            grp_open_d = 1'b0;
            mask_d     = '0;
            fwd_pend_d = 1'b1;
            tmo_d      = '0;
        end

        if (accept) begin
            pkt_id_d  = hdr.id;
            last_id_d = hdr.id;
            tmo_d     = '0;
            if (full) begin
                grp_open_d = 1'b0;
                mask_d     = '0;
                fwd_pend_d = 1'b1;
            end else begin
                grp_open_d = 1'b1;
                mask_d     = new_mask;
                // A group opened by an unforwarded frame still owes the merger a copy
                if (fwd_frame_q) fwd_pend_d = 1'b0;
                else if (!grp_open_q || wrap) fwd_pend_d = 1'b1;
            end
        end

        if (grp_done) begin
            grp_mask_d  = close_mask;
            grp_count_d = popcnt(close_mask);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StSkip;
            grp_open_q  <= 1'b0;
            mask_q      <= '0;
            last_id_q   <= '0;
            fwd_pend_q  <= 1'b1;
            fwd_frame_q <= 1'b0;
            tmo_q       <= '0;
            pkt_id_q    <= '0;
            grp_mask_q  <= '0;
            grp_count_q <= '0;
        end else begin
            state_q     <= state_d;
            grp_open_q  <= grp_open_d;
            mask_q      <= mask_d;
            last_id_q   <= last_id_d;
            fwd_pend_q  <= fwd_pend_d;
            fwd_frame_q <= fwd_frame_d;
            tmo_q       <= tmo_d;
            pkt_id_q    <= pkt_id_d;
            grp_mask_q  <= grp_mask_d;
            grp_count_q <= grp_count_d;
        end
    end

    assign bus_io.fwd_sel   = !rst && rx_en &&
                              ((first_byte && fwd_eligible) || ((state_q == StRecv) && fwd_frame_q));
    assign bus_io.pkt_done  = accept;
    assign bus_io.pkt_id    = pkt_id_d;
    assign bus_io.grp_open  = grp_open_q;
    assign bus_io.grp_done  = grp_done;
    assign bus_io.grp_mask  = grp_mask_d;
    assign bus_io.grp_count = grp_count_d;
    assign bus_io.lost      = grp_done && (grp_count_d != 3'(NCOPIES));

endmodule

// File: tb/tb_rx_copy_sequencer.sv
// Scoreboard bench: a reference grouping model queues expected packet/group events per frame.
module tb_rx_copy_sequencer;

    localparam int unsigned WHEREISID = 0;
    localparam int unsigned NC        = 5;
    localparam int unsigned MINLEN    = 8;
    localparam int unsigned TIMEOUT   = 64;

    typedef struct packed {
        logic [NC-1:0] mask;
        logic          tmo;
    } grp_exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   last_pkt_cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [3:0] pkt_q[$];
    grp_exp_t   grp_q[$];

    logic          m_open;
    logic [NC-1:0] m_mask;
    int            m_last;
    logic          m_pend;

    rx_copy_sequencer_if #(.NCOPIES(NC)) bus ();

    rx_copy_sequencer #(
        .WHEREISID(WHEREISID),
        .NCOPIES  (NC),
        .MINLEN   (MINLEN),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus_io(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_grp(input logic [NC-1:0] mask, input logic tmo);
        grp_exp_t g;
        g.mask = mask;
        g.tmo  = tmo;
        grp_q.push_back(g);
    endtask

    task automatic model_reset();
        m_open = 1'b0;
        m_mask = '0;
        m_last = 0;
        m_pend = 1'b1;
    endtask

    task automatic model_frame(input int id, input int len, input logic fwd);
        logic          good, wrap, opened;
        logic [NC-1:0] bitm;
        good = (len >= int'(MINLEN)) && (id >= 1) && (id <= int'(NC));
        if (good) good = !(m_open && m_mask[id-1]);
        if (!good) return;
        bitm = NC'(1) << (id - 1);
        wrap = m_open && (id <= m_last);
        opened = !m_open || wrap;
        pkt_q.push_back(4'(id));
        if (wrap) begin
            push_grp(m_mask, 1'b0);
            m_mask = '0;
        end
        if (!m_open) m_mask = '0;
        m_mask = m_mask | bitm;
        m_last = id;
        if (id == int'(NC)) begin
            push_grp(m_mask, 1'b0);
            m_open = 1'b0;
            m_mask = '0;
            m_pend = 1'b1;
        end else begin
            m_open = 1'b1;
            if (fwd) m_pend = 1'b0;
            else if (opened) m_pend = 1'b1;
        end
    endtask

    // rst_at >= 0 pulses reset during that byte; the remainder of the frame must be discarded
    task automatic send_frame(input int id, input int len, input int gap, input int rst_at);
        logic fwd_exp;
        int   fwd_cnt;
        fwd_exp = m_pend;
        fwd_cnt = 0;
        for (int i = 0; i < len; i++) begin
            @(posedge clk);
            #1;
            bus.rx_en_w  = 1'b1;
            bus.rxdata_w = (i == int'(WHEREISID)) ? {4'($urandom_range(15)), 4'(id)}
                                                  : 8'($urandom);
            rst = (i == rst_at);
            @(negedge clk);
            if (i > rst_at) fwd_cnt += int'(bus.fwd_sel);
            if (rst_at >= 0 && i == rst_at + 1) begin
                check_eq("rst_grp_open", bus.grp_open, 0);
                check_eq("rst_grp_mask", bus.grp_mask, 0);
                check_eq("rst_pkt_id", bus.pkt_id, 0);
                check_eq("rst_grp_count", bus.grp_count, 0);
            end
        end
        @(posedge clk);
        #1;
        bus.rx_en_w = 1'b0;
        rst = 1'b0;
        if (rst_at >= 0) begin
            model_reset();
            check_eq("fwd_tail_after_rst", fwd_cnt, 0);
        end else begin
            check_eq($sformatf("fwd_id%0d_len%0d", id, len), fwd_cnt, fwd_exp ? len : 0);
            model_frame(id, len, fwd_exp);
        end
        repeat (gap - 1) @(posedge clk);
    endtask

    task automatic idle_timeout();
        push_grp(m_mask, 1'b1);
        m_open = 1'b0;
        m_mask = '0;
        m_pend = 1'b1;
        repeat (TIMEOUT + 10) @(posedge clk);
    endtask

    always @(negedge clk) begin
        if (bus.pkt_done) begin
            check_eq("pkt_expected", pkt_q.size() > 0, 1);
            if (pkt_q.size() > 0) check_eq("pkt_id", bus.pkt_id, pkt_q.pop_front());
            last_pkt_cyc = cyc;
        end
        if (bus.grp_done) begin
            grp_exp_t g;
            check_eq("grp_expected", grp_q.size() > 0, 1);
            if (grp_q.size() > 0) begin
                g = grp_q.pop_front();
                check_eq("grp_mask", bus.grp_mask, g.mask);
                check_eq("grp_count", bus.grp_count, $countones(g.mask));
                check_eq("grp_lost", bus.lost, g.mask != '1);
                if (g.tmo) check_eq("tmo_latency", cyc - last_pkt_cyc, TIMEOUT);
                else check_eq("grp_with_pkt", bus.pkt_done, 1);
            end
        end
    end

    initial begin
        bus.rx_en_w  = 1'b0;
        bus.rxdata_w = '0;
        rst = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("reset_fwd_sel", bus.fwd_sel, 0);
        check_eq("reset_pkt_done", bus.pkt_done, 0);
        check_eq("reset_grp_open", bus.grp_open, 0);
        check_eq("reset_grp_done", bus.grp_done, 0);
        check_eq("reset_grp_mask", bus.grp_mask, 0);
        check_eq("reset_lost", bus.lost, 0);

        // Full group
        for (int id = 1; id <= 5; id++) send_frame(id, 35, 20, -1);
        // Missing copy 3
        foreach (pkt_q[i]) begin end
        send_frame(1, 35, 20, -1);
        send_frame(2, 35, 20, -1);
        send_frame(4, 35, 20, -1);
        send_frame(5, 35, 20, -1);
        // Timeout close
        send_frame(1, 35, 20, -1);
        send_frame(3, 35, 20, -1);
        idle_timeout();
        // Wrap without copy 5, then timeout on the new group
        send_frame(2, 35, 20, -1);
        send_frame(3, 35, 20, -1);
        send_frame(1, 35, 20, -1);
        idle_timeout();
        // Runt, id 0, id 9 and duplicate are ignored
        send_frame(1, 4, 20, -1);
        send_frame(0, 35, 20, -1);
        send_frame(9, 35, 20, -1);
        send_frame(1, 35, 20, -1);
        send_frame(2, 35, 20, -1);
        send_frame(2, 35, 20, -1);
        send_frame(3, 12, 20, -1);
        send_frame(4, 35, 20, -1);
        send_frame(5, 35, 20, -1);
        // Reset mid-frame with a group open
        send_frame(1, 35, 20, -1);
        send_frame(2, 35, 20, -1);
        send_frame(3, 35, 20, 10);
        send_frame(1, 35, 20, -1);
        @(negedge clk);
        check_eq("fresh_grp_open", bus.grp_open, 1);
        send_frame(5, 35, 20, -1);

        repeat (10) @(posedge clk);
        check_eq("pkt_queue_drained", pkt_q.size(), 0);
        check_eq("grp_queue_drained", grp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
